// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux into a one-entry registered output stage.
// Optional macro RR_MUX4_ARB_BACK2BACK_EN: re-arbitrate on the last beat instead of passing through IDLE.
module rr_mux4_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [3:0]       V,
  input  logic [3:0]       L,
  output logic [3:0]       R,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             O_last,
  output logic [1:0]       S,
  output logic             BUSY
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [WIDTH-1:0] o_q;
  logic             o_valid_q;
  logic             o_last_q;

  logic             sel_ready;
  logic             xfer;
  logic [2:0]       pick;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  // Returns {found, index}: first set bit of req scanning start, start+1, ... (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    case (s_q)
      2'd0:    mux_data = I0;
      2'd1:    mux_data = I1;
      2'd2:    mux_data = I2;
      default: mux_data = I3;
    endcase
    mux_last = L[s_q];
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    last_grant_d = last_grant_q;
    R            = 4'b0000;
    xfer         = 1'b0;
    pick         = 3'b000;
    sel_ready    = ~o_valid_q | O_ready;
    case (state_q)
      IDLE: begin
        pick = rr_pick(V, last_grant_q + 2'd1);
        if (pick[2]) begin
          s_d     = pick[1:0];
          state_d = LOCK;
        end
      end
      LOCK: begin
        R[s_q] = sel_ready;
        xfer   = V[s_q] & sel_ready;
        if (xfer && mux_last) begin
          last_grant_d = s_q;
`ifdef RR_MUX4_ARB_BACK2BACK_EN
          // The requester just served is masked and ranked last for the follow-on grant.
          pick = rr_pick(V & ~(4'b0001 << s_q), s_q + 2'd1);
          if (pick[2]) s_d = pick[1:0];
          else         state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q      <= IDLE;
      s_q          <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output stage: a reset discards any beat held here.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      o_q       <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else if (xfer) begin
      o_q       <= mux_data;
      o_last_q  <= mux_last;
      o_valid_q <= 1'b1;
    end else if (O_ready) begin
      o_valid_q <= 1'b0;
    end
  end

  assign O       = o_q;
  assign O_valid = o_valid_q;
  assign O_last  = o_last_q;
  assign S       = s_q;
  assign BUSY    = (state_q == LOCK);

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 WIDTH-bit mux between four valid/ready requesters.
- Drives the mux select internally and locks the grant for a whole packet, released on the LAST beat.
- Mux output is registered into a one-entry output stage with valid/ready toward the single downstream consumer.
- Sits in front of any shared datapath sink (bus, FIFO, serializer) fed by four independent sources.

Parameters:
- WIDTH, 4, data width of each requester input and of O.

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- I0  input  WIDTH  requester 0 data.
- I1  input  WIDTH  requester 1 data.
- I2  input  WIDTH  requester 2 data.
- I3  input  WIDTH  requester 3 data.
- V  input  4  per-requester valid; bit n belongs to In.
- L  input  4  per-requester last-beat flag; qualified by V[n].
- R  output  4  per-requester ready; at most one bit set.
- O  output  WIDTH  registered mux output data.
- O_valid  output  1  O holds a beat.
- O_ready  input  1  downstream accepts the beat.
- O_last  output  1  registered L of the beat in O.
- S  output  2  current grant / mux select.
- BUSY  output  1  a packet is locked.

Behaviour:
- Reset (ASYNCRESETN=0, effective immediately, independent of CLK):
  - state=IDLE, S=0, BUSY=0, R=0, O=0, O_valid=0, O_last=0.
  - Internal last_grant=3, so requester 0 has first priority.
  - Reset mid-packet aborts the packet; the beat held in O is discarded.
- States: IDLE, LOCK. BUSY=1 iff state=LOCK.
- IDLE:
  - R=0.
  - If V!=0, the winner is the first set V bit scanning last_grant+1, +2, +3, +4 (mod 4).
  - Next cycle: S<=winner, state<=LOCK.
  - If V=0, stay in IDLE and S holds its value.
- LOCK:
  - R[S]=(~O_valid | O_ready); all other R bits are 0.
  - Transfer when V[S] & R[S]: O<=I[S], O_last<=L[S], O_valid<=1.
  - On a transfer with L[S]=1: last_grant<=S, state<=IDLE.
  - If V[S]=0, the grant stays locked indefinitely; there is no timeout.
  - Other requesters' V are ignored while locked.
- Output stage:
  - If there is no transfer and O_ready=1, O_valid<=0.
  - While O_valid & ~O_ready, O and O_last hold stable; R[S]=0, so no overwrite occurs.
  - O_ready with O_valid=0 has no effect.
- Latency:
  - V asserted in IDLE at cycle t gives grant at t+1.
  - First transfer at t+1 if the output stage is free; O_valid at t+2.
  - Full throughput of 1 beat/cycle while locked and O_ready=1.
  - Default mode inserts one IDLE cycle between packets.
- Single-beat packet: V and L both set on the first beat. LOCK lasts one cycle.
- Simultaneous requests are resolved purely by the rotating priority. A requester that was just served has the lowest priority next.
- S only changes on an IDLE→LOCK transition, never mid-packet.

Optional Feature:
- RR_MUX4_ARB_BACK2BACK_EN.
- Defined: on a LOCK transfer with L[S]=1, re-arbitrate in the same cycle.
  - Use V with the served bit masked, and priority starting at S+1.
  - If any remains, S<=winner and state stays LOCK, so there is no idle cycle.
  - Otherwise go to IDLE.
  - last_grant updates as in default mode.
- Undefined: always pass through IDLE between packets, as in default mode.

Test Plan:
- Reset mid-packet: assert ASYNCRESETN=0 between clock edges during LOCK with O_valid=1 → immediately BUSY=0, R=0, O_valid=0, O=0, S=0. After release, V=4'b1000 is granted as S=3.
- Fairness: V=4'b1111 continuously, every beat L=1, O_ready=1 → grant sequence S=0,1,2,3,0. Each packet is followed by one IDLE cycle (default mode).
- Packet lock: requester 2 sends 3 beats (A,B,C with L on C) while V[0] stays high → O shows A,B,C on consecutive cycles with S=2 throughout. S=0 only after C, and O_last=1 coincides with C.
- Backpressure: O_ready=0 for 3 cycles with O_valid=1 → O holds its value and R=0. When O_ready=1 the next beat loads on the following edge, with no loss or duplication.
- Stall in packet: granted requester 1 drops V for 2 cycles mid-packet while V[3]=1 → S stays 1, BUSY=1, R[3]=0. The packet resumes and completes normally.
- With RR_MUX4_ARB_BACK2BACK_EN: V=4'b0101, single-beat packets → S goes 0→2 with no IDLE cycle, giving consecutive O_valid beats I0 then I2.
